ysyx_23060187_div: RTL and testbench

Iterative multi-cycle integer divide/remainder unit. It sits beside the single-cycle ALU in the execute stage and handles the RV32M DIV/DIVU/REM/REMU operations, which the ALU does not implement. The upstream decode/execute control issues requests over a valid/ready handshake. The unit returns one 32-bit result per request over a second valid/ready handshake.

---
 rtl/ysyx_23060187_div.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_23060187_div.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060187_div.sv
// ysyx_23060187_div: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per cycle in CALC. Divide-by-zero and signed
// overflow skip the iteration and deliver a precomputed value one cycle later.
module ysyx_23060187_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL1_C = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MINN_C = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's complement negation.
    function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
        return ~v + ONE_C;
    endfunction

    state_t          state_r, state_s;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r, spec_res_r, result_r;
    logic [CW-1:0]   cnt_r;
    logic            op_rem_r, neg_q_r, neg_r_r, special_r;
    logic            in_ready_r, out_valid_r, busy_r;

    logic            accept_s, signed_s, dvd_neg_s, dvs_neg_s, div0_s, ovf_s;
    logic [XLEN-1:0] dvd_mag_s, dvs_mag_s, spec_val_s;
    logic [XLEN:0]   shin_s, trial_s;
    logic            qbit_s;
    logic [XLEN-1:0] rem_nx_s, quo_nx_s, fin_s, res_nx_s;
    logic            ld_res_s;

    // Request decode: operand magnitudes, signs and the special-case value.
    always_comb begin
        accept_s  = in_valid && (state_r == IDLE) && !flush;
        signed_s  = ~op[0];
        dvd_neg_s = signed_s & dividend[XLEN-1];
        dvs_neg_s = signed_s & divisor[XLEN-1];
        dvd_mag_s = dvd_neg_s ? neg_f(dividend) : dividend;
        dvs_mag_s = dvs_neg_s ? neg_f(divisor) : divisor;
        div0_s    = (divisor == ZERO_C);
        ovf_s     = signed_s && (dividend == MINN_C) && (divisor == ALL1_C);
        if (div0_s) begin
            spec_val_s = op[1] ? dividend : ALL1_C;
        end else if (ovf_s) begin
            spec_val_s = op[1] ? ZERO_C : MINN_C;
        end else begin
            spec_val_s = ZERO_C;
        end
    end

    // One restoring step plus the sign fixup applied to the final step.
    always_comb begin
        shin_s   = {rem_r, quo_r[XLEN-1]};
        trial_s  = shin_s - {1'b0, dvs_r};
        qbit_s   = ~trial_s[XLEN];
        rem_nx_s = qbit_s ? trial_s[XLEN-1:0] : shin_s[XLEN-1:0];
        quo_nx_s = {quo_r[XLEN-2:0], qbit_s};
        if (op_rem_r) begin
            fin_s = neg_r_r ? neg_f(rem_nx_s) : rem_nx_s;
        end else begin
            fin_s = neg_q_r ? neg_f(quo_nx_s) : quo_nx_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_s  = state_r;
        ld_res_s = 1'b0;
        res_nx_s = result_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_s = IDLE;
                end else if (special_r) begin
                    state_s  = DONE;
                    ld_res_s = 1'b1;
                    res_nx_s = spec_res_r;
                end else if (cnt_r == CW'(1)) begin
                    state_s  = DONE;
                    ld_res_s = 1'b1;
                    res_nx_s = fin_s;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Operand capture on acceptance, iteration in CALC, result on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r      <= ZERO_C;
            quo_r      <= ZERO_C;
            dvs_r      <= ZERO_C;
            spec_res_r <= ZERO_C;
            result_r   <= ZERO_C;
            cnt_r      <= {CW{1'b0}};
            op_rem_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            special_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                rem_r      <= ZERO_C;
                quo_r      <= dvd_mag_s;
                dvs_r      <= dvs_mag_s;
                spec_res_r <= spec_val_s;
                cnt_r      <= CW'(XLEN);
                op_rem_r   <= op[1];
                neg_q_r    <= dvd_neg_s ^ dvs_neg_s;
                neg_r_r    <= dvd_neg_s;
                special_r  <= div0_s | ovf_s;
            end else if ((state_r == CALC) && !flush && !special_r) begin
                rem_r <= rem_nx_s;
                quo_r <= quo_nx_s;
                cnt_r <= cnt_r - CW'(1);
            end
            if (ld_res_s) begin
                result_r <= res_nx_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

endmodule

// File: tb/tb_ysyx_23060187_div.sv
// Scoreboard bench for ysyx_23060187_div: the driver queues expected results
// and latencies, a monitor pops them when out_valid rises.
module tb_ysyx_23060187_div;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] dividend, divisor, result;
    logic        in_ready, out_valid, busy;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    ysyx_23060187_div #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Monitor: one comparison set per rising out_valid.
    initial begin
        exp_t e;
        logic ov_prev;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !ov_prev) begin
                if (q.size() == 0) begin
                    timeout("unexpected_out_valid");
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_result"}, result, e.exp);
                    chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input bit track, input string nm);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            timeout({nm, "_in_ready"});
        end else begin
            in_valid = 1'b1;
            op       = o;
            dividend = a;
            divisor  = b;
            if (track) q.push_back('{e, lat, cyc + 1, nm});
            @(negedge clk);
            in_valid = 1'b0;
            op       = ~o;
            dividend = ~a;
            divisor  = b ^ 32'h5A5A_5A5A;
        end
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !out_valid && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout({nm, "_idle"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; dividend = 32'h0; divisor = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        issue(2'b01, 32'd100, 32'd7, 32'd14, 32, 1'b1, "divu_100_7");      wait_idle("a");
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32, 1'b1, "remu_100_7");       wait_idle("b");
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 1'b1, "div_m7_2"); wait_idle("c");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 1'b1, "rem_m7_2"); wait_idle("d");
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 1'b1, "div_7_m2"); wait_idle("e");
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32, 1'b1, "rem_7_m2");   wait_idle("f");
        issue(2'b01, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, "divu_by0");  wait_idle("g");
        issue(2'b10, 32'h1234, 32'h0, 32'h1234, 1, 1'b1, "rem_by0");       wait_idle("h");
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1, "div_ovf"); wait_idle("i");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b1, "rem_ovf"); wait_idle("j");
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32, 1'b1, "divu_big"); wait_idle("k");
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 1'b1, "remu_big"); wait_idle("l");
        issue(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 32, 1'b1, "div_min_2"); wait_idle("m");

        // Back-pressure: result must hold and no request may be taken.
        out_ready = 1'b0;
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, 1'b1, "bp_divu");
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) timeout("bp_out_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_result", result, 32'hFFFF_FFFF);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_out_valid", 32'(out_valid), 32'd0);
        chk("bp_after_in_ready", 32'(in_ready), 32'd1);
        chk("bp_after_busy", 32'(busy), 32'd0);

        // Flush five cycles into CALC.
        issue(2'b01, 32'd100, 32'd7, 32'd0, 0, 1'b0, "flushed");
        repeat (4) @(negedge clk);
        chk("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_result_kept", result, 32'hFFFF_FFFF);
        // Request presented together with flush must be ignored.
        in_valid = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_req_ignored", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_output", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of CALC.
        issue(2'b01, 32'd100, 32'd7, 32'd0, 0, 1'b0, "reset_mid");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b01, 32'd9, 32'd3, 32'd3, 32, 1'b1, "divu_9_3"); wait_idle("n");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
